tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter DW, default 2, width of each channel word.
REQ-002 Parameter NCH, default 4, channels per frame; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  DW  time-multiplexed channel word.
REQ-006 din_valid  input  1  din carries a valid word this cycle.
REQ-007 sync  input  1  frame marker, qualified by din_valid; word is channel 0.
REQ-008 o0, o1, o2, o3  output  DW each  demultiplexed channel words of the last complete frame.
REQ-009 slot  output  2  index of the channel expected on the next valid beat.
REQ-010 frame_valid  output  1  one-cycle pulse: o0..o3 updated with a new complete frame.
REQ-011 frame_err  output  1  one-cycle pulse: sync seen mid-frame; partial frame discarded.

Function
REQ-012 A beat is a rising edge with din_valid=1; cycles with din_valid=0 change nothing except clearing the pulses.
REQ-013 sync with din_valid=0 is ignored.
REQ-014 Beat with sync=1: din is stored to shadow slot 0; slot becomes 1.
REQ-015 Beat with sync=1 while slot!=0: additionally frame_err=1 for the next cycle; shadow slots 1..3 are invalidated.
REQ-016 Beat with sync=0 while slot=0: the beat is dropped; slot stays 0 (receiver waits for sync); no error.
REQ-017 Beat with sync=0 while slot in 1..3: din is stored to shadow[slot]; slot increments.
REQ-018 Beat written to slot 3: on that edge o0..o2 load shadow 0..2, o3 loads din; slot wraps to 0; frame_valid=1 for exactly the next cycle.
REQ-019 Latency: o0..o3 reflect the new frame in the cycle immediately after the slot-3 beat, all four updated atomically.
REQ-020 o0..o3 hold their values between complete frames; a partial or aborted frame never changes them.
REQ-021 Back-to-back frames (sync on the beat directly after a slot-3 beat) are accepted with no idle cycle; frame_valid may then pulse every 4 beats.
REQ-022 frame_valid and frame_err are never asserted in the same cycle.
REQ-023 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-024 While rst=1 on a rising edge: o0..o3=0, slot=0, frame_valid=0, frame_err=0, shadow slots cleared.
REQ-025 rst has priority over all beats; a frame in progress at reset is discarded with no frame_valid and no frame_err.
REQ-026 The first edge after rst deasserts is a normal cycle; reception requires a fresh sync.

Structure
REQ-027 DW, NCH and slot-index width are shared constants in package tdm_pkg, also used by the matching 4:1 transmit-side mux.
REQ-028 Slot tracking is one sub-module, tdm_slot_ctr (2-bit counter with sync-load to 1, increment, wrap, and mid-frame-sync error flag).
REQ-029 Shadow registers, output registers and pulse generation are in tdm_demux4 itself.

Verification
REQ-030 Beats 00(sync),01,10,11 on consecutive cycles -> next cycle o0..o3=00,01,10,11, frame_valid high 1 cycle, slot=0.
REQ-031 Same four words with 2 idle cycles (din_valid=0) between beats -> identical outputs; frame_valid only after the fourth beat.
REQ-032 Beats 11(sync),10, then 01(sync),00,11,10 -> frame_err 1 cycle after the second sync; then o0..o3=01,00,11,10 with one frame_valid.
REQ-033 Beats 10,11 without sync after reset -> dropped; slot=0; outputs stay 00; no pulses.
REQ-034 rst=1 after beats 00(sync),01 -> all outputs 0; following 11,10,01 without sync are dropped; no frame_valid.
REQ-035 Two back-to-back frames 00,01,10,11 then 11,10,01,00 -> frame_valid pulses 4 cycles apart; final o0..o3=11,10,01,00.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and helpers for the 4-channel TDM link (receive demux and
// transmit-side mux use the same word width, channel count and slot index).
package tdm_pkg;

  localparam int unsigned TDM_DW     = 2;
  localparam int unsigned TDM_NCH    = 4;
  localparam int unsigned TDM_SLOT_W = 2;

  typedef logic [TDM_SLOT_W-1:0] slot_t;

  localparam slot_t SLOT_FIRST = '0;
  localparam slot_t SLOT_LAST  = slot_t'(TDM_NCH - 1);

  // What a single clock edge means for the receiver.
  typedef enum logic [1:0] {
    BEAT_IDLE, // din_valid low: nothing happens
    BEAT_SYNC, // frame marker: word is channel 0
    BEAT_DATA, // mid-frame word for the current slot
    BEAT_DROP  // unsynchronised word: discarded while hunting for sync
  } beat_kind_t;

  function automatic beat_kind_t classify_beat(input logic  valid,
                                               input logic  sync,
                                               input slot_t slot);
    if (!valid) begin
      return BEAT_IDLE;
    end
    if (sync) begin
      return BEAT_SYNC;
    end
    if (slot == SLOT_FIRST) begin
      return BEAT_DROP;
    end
    return BEAT_DATA;
  endfunction

  function automatic slot_t slot_inc(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot tracker for the TDM receiver: sync loads the counter to 1, data beats
// advance it, the last channel wraps it to 0, and a sync arriving while the
// counter is not at 0 raises a (combinational) mid-frame error flag.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned NCH = TDM_NCH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat,
  input  logic                  sync,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  wr_en,
  output logic [TDM_SLOT_W-1:0] wr_idx,
  output logic                  frame_done,
  output logic                  sync_err
);

  localparam slot_t LAST = slot_t'(NCH - 1);

  slot_t      slot_q;
  slot_t      slot_d;
  beat_kind_t kind;

  // Decode the current edge against the expected slot.
  always_comb begin
    kind = classify_beat(beat, sync, slot_q);
  end

  // Next slot and per-beat strobes for the shadow/output registers.
  always_comb begin
    slot_d     = slot_q;
    wr_en      = 1'b0;
    wr_idx     = slot_q;
    frame_done = 1'b0;
    sync_err   = 1'b0;
    unique case (kind)
      BEAT_SYNC: begin
        wr_en    = 1'b1;
        wr_idx   = SLOT_FIRST;
        slot_d   = slot_t'(1);
        sync_err = (slot_q != SLOT_FIRST);
      end
      BEAT_DATA: begin
        wr_en      = 1'b1;
        frame_done = (slot_q == LAST);
        slot_d     = (slot_q == LAST) ? SLOT_FIRST : slot_inc(slot_q);
      end
      default: begin
        // idle edges and unsynchronised drops leave the slot untouched
      end
    endcase
  end

  // Slot register with synchronous reset back to "waiting for sync".
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT_FIRST;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM receiver: collects a frame of channel words into shadow
// registers and publishes all four channels atomically when the last channel
// arrives. Partial or aborted frames never reach the outputs.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned DW  = TDM_DW,
  parameter int unsigned NCH = TDM_NCH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         din,
  input  logic                  din_valid,
  input  logic                  sync,
  output logic [DW-1:0]         o0,
  output logic [DW-1:0]         o1,
  output logic [DW-1:0]         o2,
  output logic [DW-1:0]         o3,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  frame_valid,
  output logic                  frame_err
);

  logic                  wr_en;
  logic [TDM_SLOT_W-1:0] wr_idx;
  logic                  frame_done;
  logic                  sync_err;

  // The last channel is taken straight from din on the completing edge, so
  // only channels 0..NCH-2 need shadow storage.
  logic [DW-1:0] shadow_q [NCH-1];
  logic [DW-1:0] shadow_d [NCH-1];
  logic [DW-1:0] out_q    [NCH];
  logic [DW-1:0] out_d    [NCH];
  logic          frame_valid_q;
  logic          frame_valid_d;
  logic          frame_err_q;
  logic          frame_err_d;

  tdm_slot_ctr #(
    .NCH (NCH)
  ) u_slot_ctr (
    .clk        (clk),
    .rst        (rst),
    .beat       (din_valid),
    .sync       (sync),
    .slot       (slot),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // Shadow capture, frame publication and one-cycle status pulses.
  always_comb begin
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (sync_err) begin
      frame_err_d = 1'b1;
      for (int unsigned i = 1; i < NCH - 1; i++) begin
        shadow_d[i] = '0;
      end
    end

    for (int unsigned i = 0; i < NCH - 1; i++) begin
      if (wr_en && (wr_idx == slot_t'(i))) begin
        shadow_d[i] = din;
      end
    end

    if (frame_done) begin
      frame_valid_d = 1'b1;
      for (int unsigned i = 0; i < NCH - 1; i++) begin
        out_d[i] = shadow_q[i];
      end
      out_d[NCH-1] = din;
    end
  end

  // State registers; reset discards any frame in progress silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH - 1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        out_q[i] <= '0;
      end
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign o0          = out_q[0];
  assign o1          = out_q[1];
  assign o2          = out_q[2];
  assign o3          = out_q[3];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4: directed frame scenarios plus a randomized run
// against a queue-based frame assembler model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] din = 2'b00;
  logic [1:0] o0, o1, o2, o3;
  logic [1:0] slot;
  logic       frame_valid;
  logic       frame_err;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: words of the frame being collected, last published frame, pulses.
  logic [1:0] m_part [$];
  logic [1:0] m_o [4];
  bit         m_fv;
  bit         m_fe;

  tdm_demux4 #(
    .DW  (2),
    .NCH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .o0          (o0),
    .o1          (o1),
    .o2          (o2),
    .o3          (o3),
    .slot        (slot),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  assign outs = {o0, o1, o2, o3};

  function automatic logic [7:0] m_outs();
    return {m_o[0], m_o[1], m_o[2], m_o[3]};
  endfunction

  function automatic logic [1:0] m_slot();
    return 2'(m_part.size());
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit s, input logic [1:0] d);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_part.delete();
      for (int i = 0; i < 4; i++) m_o[i] = 2'b00;
    end else if (v) begin
      if (s) begin
        if (m_part.size() != 0) m_fe = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end else if (m_part.size() != 0) begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          for (int i = 0; i < 4; i++) m_o[i] = m_part[i];
          m_part.delete();
          m_fv = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input bit r, input bit v, input bit s, input logic [1:0] d);
    @(negedge clk);
    rst = r;
    din_valid = v;
    sync = s;
    din = d;
    @(posedge clk);
    model_edge(r, v, s, d);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom));
  endtask

  task automatic apply_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'b00);
    cycle(1'b1, 1'b1, 1'b1, 2'b11);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (outs !== 8'h00) begin n_bad++; $display("FAIL reset_outs got %h want 00", outs); end
    n_cmp++; if (slot !== 2'd0) begin n_bad++; $display("FAIL reset_slot got %0d want 0", slot); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe got %b want 0", frame_err); end
    // first edge after release is a normal cycle
    cycle(1'b0, 1'b1, 1'b1, 2'b10);
    n_cmp++; if (slot !== 2'd1) begin n_bad++; $display("FAIL post_reset_sync_slot got %0d want 1", slot); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL post_reset_sync_fe got %b want 0", frame_err); end
  endtask

  task automatic test_basic();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b1, 2'b00);
    cycle(1'b0, 1'b1, 1'b0, 2'b01);
    cycle(1'b0, 1'b1, 1'b0, 2'b10);
    n_cmp++; if (slot !== 2'd3) begin n_bad++; $display("FAIL basic_slot3 got %0d want 3", slot); end
    n_cmp++; if (outs !== 8'h00 || frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early got %h/%b want 00/0", outs, frame_valid); end
    cycle(1'b0, 1'b1, 1'b0, 2'b11);
    n_cmp++; if (outs !== 8'h1B) begin n_bad++; $display("FAIL basic_outs got %h want 1b", outs); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_fv got %b want 1", frame_valid); end
    n_cmp++; if (slot !== 2'd0) begin n_bad++; $display("FAIL basic_slot_wrap got %0d want 0", slot); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL basic_fe got %b want 0", frame_err); end
    idle();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_fv_pulse got %b want 0", frame_valid); end
    n_cmp++; if (outs !== 8'h1B) begin n_bad++; $display("FAIL basic_hold got %h want 1b", outs); end
  endtask

  task automatic test_idle_gaps();
    int fv_count = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, k == 0, 2'(k));
      if (frame_valid === 1'b1) fv_count++;
      if (k < 3) begin
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL gaps_fv_early beat %0d got %b want 0", k, frame_valid); end
        for (int g = 0; g < 2; g++) begin
          idle();
          if (frame_valid === 1'b1) fv_count++;
        end
      end
    end
    n_cmp++; if (frame_valid !== 1'b1 || outs !== 8'h1B) begin n_bad++; $display("FAIL gaps_frame got %b/%h want 1/1b", frame_valid, outs); end
    for (int g = 0; g < 3; g++) begin
      idle();
      if (frame_valid === 1'b1) fv_count++;
    end
    n_cmp++; if (fv_count != 1) begin n_bad++; $display("FAIL gaps_fv_count got %0d want 1", fv_count); end
  endtask

  task automatic test_mid_sync();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b1, 2'b11);
    cycle(1'b0, 1'b1, 1'b0, 2'b10);
    cycle(1'b0, 1'b1, 1'b1, 2'b01);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL midsync_fe got %b want 1", frame_err); end
    n_cmp++; if (frame_valid !== 1'b0 || slot !== 2'd1 || outs !== 8'h00) begin n_bad++; $display("FAIL midsync_state got fv=%b slot=%0d outs=%h want 0/1/00", frame_valid, slot, outs); end
    cycle(1'b0, 1'b1, 1'b0, 2'b00);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midsync_fe_pulse got %b want 0", frame_err); end
    cycle(1'b0, 1'b1, 1'b0, 2'b11);
    cycle(1'b0, 1'b1, 1'b0, 2'b10);
    n_cmp++; if (frame_valid !== 1'b1 || outs !== 8'h4E) begin n_bad++; $display("FAIL midsync_frame got %b/%h want 1/4e", frame_valid, outs); end
  endtask

  task automatic test_no_sync();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b0, 2'b10);
    n_cmp++; if (slot !== 2'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL nosync_b0 got slot=%0d fv=%b fe=%b want 0/0/0", slot, frame_valid, frame_err); end
    cycle(1'b0, 1'b1, 1'b0, 2'b11);
    n_cmp++; if (slot !== 2'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL nosync_b1 got slot=%0d fv=%b fe=%b want 0/0/0", slot, frame_valid, frame_err); end
    n_cmp++; if (outs !== 8'h00) begin n_bad++; $display("FAIL nosync_outs got %h want 00", outs); end
  endtask

  task automatic test_reset_mid_frame();
    int fv_count = 0;
    apply_reset();
    cycle(1'b0, 1'b1, 1'b1, 2'b00);
    cycle(1'b0, 1'b1, 1'b0, 2'b01);
    cycle(1'b1, 1'b0, 1'b0, 2'b00);
    n_cmp++; if (outs !== 8'h00 || slot !== 2'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_state got outs=%h slot=%0d fv=%b fe=%b want 00/0/0/0", outs, slot, frame_valid, frame_err); end
    cycle(1'b0, 1'b1, 1'b0, 2'b11); if (frame_valid === 1'b1) fv_count++;
    cycle(1'b0, 1'b1, 1'b0, 2'b10); if (frame_valid === 1'b1) fv_count++;
    cycle(1'b0, 1'b1, 1'b0, 2'b01); if (frame_valid === 1'b1) fv_count++;
    n_cmp++; if (slot !== 2'd0) begin n_bad++; $display("FAIL rstmid_slot got %0d want 0", slot); end
    n_cmp++; if (fv_count != 0) begin n_bad++; $display("FAIL rstmid_fv_count got %0d want 0", fv_count); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] words [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    int fv_at [$];
    int fe_count = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, (k % 4) == 0, words[k]);
      if (frame_valid === 1'b1) fv_at.push_back(k);
      if (frame_err === 1'b1) fe_count++;
    end
    n_cmp++; if (fv_at.size() != 2) begin n_bad++; $display("FAIL b2b_fv_count got %0d want 2", fv_at.size()); end
    if (fv_at.size() == 2) begin
      n_cmp++; if (fv_at[0] != 3 || fv_at[1] != 7) begin n_bad++; $display("FAIL b2b_fv_beats got %0d,%0d want 3,7", fv_at[0], fv_at[1]); end
    end
    n_cmp++; if (fe_count != 0) begin n_bad++; $display("FAIL b2b_fe_count got %0d want 0", fe_count); end
    n_cmp++; if (outs !== 8'hE4) begin n_bad++; $display("FAIL b2b_outs got %h want e4", outs); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 70,
            $urandom_range(0, 3) == 0, 2'($urandom));
      n_cmp++; if (outs !== m_outs()) begin n_bad++; $display("FAIL rand_outs cyc %0d got %h want %h", n, outs, m_outs()); end
      n_cmp++; if (slot !== m_slot()) begin n_bad++; $display("FAIL rand_slot cyc %0d got %0d want %0d", n, slot, m_slot()); end
      n_cmp++; if (frame_valid !== m_fv) begin n_bad++; $display("FAIL rand_fv cyc %0d got %b want %b", n, frame_valid, m_fv); end
      n_cmp++; if (frame_err !== m_fe) begin n_bad++; $display("FAIL rand_fe cyc %0d got %b want %b", n, frame_err, m_fe); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_gaps();
    test_mid_sync();
    test_no_sync();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
